imem_loader: RTL and testbench

//  Boot-time firmware loader: write-side initiator for the 64KB instruction memory. Accepts a framed

---
 rtl/soc_boot_pkg.sv | 21 ++
 rtl/imem_loader_wordpack.sv | 39 +++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/soc_boot_pkg.sv
// rtl/soc_boot_pkg.sv - shared boot loader state encoding and error codes
package soc_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/imem_loader_wordpack.sv
// rtl/imem_loader_wordpack.sv - little-endian byte-to-word packer with 8-bit additive checksum
module imem_loader_wordpack
    import soc_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic [7:0]  o_sum
);

    logic [1:0]  r_idx;
    logic [23:0] r_sh;
    logic [7:0]  r_sum;

    // Earlier bytes enter at the top and slide down, so byte 0 ends up in bits [7:0].
    assign o_word_done = i_valid && (r_idx == 2'd3);
    assign o_word      = {i_data, r_sh};
    assign o_sum       = r_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
            r_sh  <= 24'd0;
            r_sum <= 8'd0;
        end else if (i_start) begin
            r_idx <= 2'd0;
            r_sum <= 8'd0;
        end else if (i_valid) begin
            r_idx <= r_idx + 2'd1;
            r_sh  <= {i_data, r_sh[23:8]};
            r_sum <= r_sum + i_data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream firmware loader driving the instruction memory write port
module imem_loader
    import soc_boot_pkg::*;
#(
    parameter int         ADDR_W      = 14,
    parameter int         BASE_WORD   = 0,
    parameter int         DEPTH_WORDS = 16384,
    parameter logic [7:0] MAGIC       = DEFAULT_MAGIC,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);

    ldr_state_t        r_state, w_next;
    logic [1:0]        r_err_code, w_err_next;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [31:0]       r_tmo;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_words;

    logic        w_acc, w_start, w_data_acc, w_word_done, w_len_bad, w_tmo_hit;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic [7:0]  w_sum;

    assign busy      = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                       (r_state == ST_DATA)   || (r_state == ST_CSUM);
    assign in_ready  = enable && (busy || (r_state == ST_IDLE));
    assign w_acc     = in_valid && in_ready;
    assign w_start   = w_acc && (r_state == ST_IDLE) && (in_data == MAGIC);
    assign w_data_acc = w_acc && (r_state == ST_DATA);
    assign w_len     = {in_data, r_len_lo};
    assign w_len_bad = (w_len == 16'd0) ||
                       ((32'(BASE_WORD) + {16'd0, w_len}) > 32'(DEPTH_WORDS));
    assign w_tmo_hit = busy && !w_acc && (r_tmo == 32'(TIMEOUT_CYC - 1));

    assign done          = (r_state == ST_DONE);
    assign error         = (r_state == ST_ERR);
    assign err_code      = r_err_code;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wstrb     = r_we ? 4'hF : 4'h0;
    assign words_written = r_words;

    imem_loader_wordpack u_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_valid     (w_data_acc),
        .i_data      (in_data),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_sum       (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_next;
            r_err_code <= w_err_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err_code;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_LEN_LO;
            ST_LEN_LO: if (w_acc) w_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_acc) begin
                    if (w_len_bad) begin
                        w_next     = ST_ERR;
                        w_err_next = ERR_LEN;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA:   if (w_word_done && (r_word_cnt == r_len - 16'd1)) w_next = ST_CSUM;
            ST_CSUM: begin
                if (w_acc) begin
                    if (in_data == w_sum) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_ERR;
                        w_err_next = ERR_CSUM;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (clear) begin
                    w_next     = ST_IDLE;
                    w_err_next = ERR_NONE;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_next     = ST_ERR;
            w_err_next = ERR_TMO;
        end
    end

    // The write for a completed word is registered, so it still issues when the FSM moves on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_tmo      <= 32'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_words    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_word_cnt <= 16'd0;
                r_words    <= '0;
            end
            if (w_acc && (r_state == ST_LEN_LO)) r_len_lo <= in_data;
            if (w_acc && (r_state == ST_LEN_HI)) r_len <= w_len;
            if (w_word_done) begin
                r_we       <= 1'b1;
                r_addr     <= ADDR_W'(32'(BASE_WORD) + {16'd0, r_word_cnt});
                r_wdata    <= w_word;
                r_word_cnt <= r_word_cnt + 16'd1;
                r_words    <= r_words + (ADDR_W+1)'(1);
            end
            if (busy && !w_acc) r_tmo <= r_tmo + 32'd1;
            else                r_tmo <= 32'd0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, enable, clear, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, done, error;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  err_code;
    logic [14:0] words_written;

    logic        h_in_ready, h_mem_we, h_busy, h_done, h_error;
    logic [13:0] h_mem_addr;
    logic [31:0] h_mem_wdata;
    logic [3:0]  h_mem_wstrb;
    logic [1:0]  h_err_code;
    logic [14:0] h_words_written;

    int n_total = 0;
    int n_bad   = 0;
    int n_wr    = 0;
    logic [13:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int base;

    always #5 clk = ~clk;

    imem_loader #(.TIMEOUT_CYC(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .words_written(words_written)
    );

    imem_loader #(.TIMEOUT_CYC(16), .BASE_WORD(16383)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .mem_we(h_mem_we), .mem_addr(h_mem_addr), .mem_wdata(h_mem_wdata),
        .mem_wstrb(h_mem_wstrb), .busy(h_busy), .done(h_done), .error(h_error),
        .err_code(h_err_code), .words_written(h_words_written)
    );

    always @(negedge clk) begin
        if (mem_we && n_wr < 64) begin
            wr_addr[n_wr] = mem_addr;
            wr_data[n_wr] = mem_wdata;
            if (mem_wstrb !== 4'hF) $display("FAIL wstrb got=%h exp=f", mem_wstrb);
            n_wr = n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_errcode", err_code, 0);
        chk("rst_words", words_written, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ready", in_ready, 1);

        // Good two-word frame; the high-base instance must reject its length.
        base = n_wr;
        send_q('{8'hA5, 8'h02, 8'h00});
        chk("hi_len_err", h_error, 1);
        chk("hi_len_code", h_err_code, 2'b01);
        chk("a_busy", busy, 1);
        send_q('{8'h11, 8'h22, 8'h33, 8'h44});
        chk("a_we_first", mem_we, 1);
        chk("a_words_first", words_written, 1);
        send_q('{8'h55, 8'h66, 8'h77, 8'h88, 8'h64});
        chk("a_done", done, 1);
        chk("a_error", error, 0);
        chk("a_errcode", err_code, 0);
        chk("a_words", words_written, 2);
        chk("a_nwr", n_wr - base, 2);
        chk("a_addr0", wr_addr[base], 0);
        chk("a_data0", wr_data[base], 32'h44332211);
        chk("a_addr1", wr_addr[base+1], 1);
        chk("a_data1", wr_data[base+1], 32'h88776655);

        do_clear();
        chk("clr_done", done, 0);
        chk("clr_words_kept", words_written, 2);

        // Same frame with a wrong checksum.
        base = n_wr;
        send_q('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h65});
        chk("b_error", error, 1);
        chk("b_errcode", err_code, 2'b10);
        chk("b_done", done, 0);
        chk("b_nwr", n_wr - base, 2);

        // Zero length.
        do_clear();
        chk("clr_err", error, 0);
        base = n_wr;
        send_q('{8'hA5, 8'h00, 8'h00});
        step();
        chk("c_error", error, 1);
        chk("c_errcode", err_code, 2'b01);
        chk("c_nwr", n_wr - base, 0);

        // Garbage ahead of a one-word frame.
        do_clear();
        base = n_wr;
        send_q('{8'h00, 8'hFF, 8'h5A});
        chk("d_idle", busy, 0);
        send_q('{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38});
        chk("d_done", done, 1);
        chk("d_words", words_written, 1);
        chk("d_nwr", n_wr - base, 1);
        chk("d_addr", wr_addr[base], 0);
        chk("d_data", wr_data[base], 32'hEFBEADDE);

        // Stall after two data bytes.
        do_clear();
        send_q('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
        repeat (15) step();
        chk("e_no_tmo_15", error, 0);
        chk("e_busy_15", busy, 1);
        step();
        chk("e_tmo_16", error, 1);
        chk("e_tmo_code", err_code, 2'b11);

        // Reset on the edge that would complete a word.
        do_clear();
        base = n_wr;
        send_q('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03});
        in_valid = 1'b1; in_data = 8'h04; rst_n = 1'b0;
        step();
        chk("f_rst_we", mem_we, 0);
        chk("f_rst_busy", busy, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("f_rst_nwr", n_wr - base, 0);
        send_q('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
        chk("f_done", done, 1);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        #1;
        chk("f_ready_done", in_ready, 0);
        step();
        clear = 1'b0;
        chk("f_idle_done", done, 0);
        chk("f_idle_busy", busy, 0);
        chk("f_words_kept", words_written, 1);
        step();
        in_valid = 1'b0;
        chk("f_magic_busy", busy, 1);
        chk("f_magic_words", words_written, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
